// File: rtl/spi_master_if.sv
// Bus bundle for spi_master: control/data handshake toward the boot controller plus the SPI pins.
// The master modport is the view taken by spi_master itself; slave is the environment's view.
interface spi_master_if #(
  parameter int DATA_W = 48
);
  logic              spi_fbo_i;
  logic              spi_start_i;
  logic [DATA_W-1:0] transmission_data_i;
  logic [1:0]        clock_divider_i;
  logic              MISO;
  logic              SS;
  logic              SCK;
  logic              MOSI;
  logic              done;
  logic [DATA_W-1:0] received_data_o;

  modport master (
    input  spi_fbo_i, spi_start_i, transmission_data_i, clock_divider_i, MISO,
    output SS, SCK, MOSI, done, received_data_o
  );

  modport slave (
    output spi_fbo_i, spi_start_i, transmission_data_i, clock_divider_i, MISO,
    input  SS, SCK, MOSI, done, received_data_o
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master moving one DATA_W-bit word per edge-armed start, with programmable SCK divider.
// Optional build macro SPI_MASTER_LOOPBACK_EN: receive shifter samples internal MOSI instead of MISO.
module spi_master #(
  parameter int DATA_W = 48
) (
  input  logic          spi_clk_i,
  input  logic          spi_rst_i,
  spi_master_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic              fbo_q, fbo_d;
  logic [1:0]        div_q, div_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [5:0]        bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [2:0]        h_last;
  logic              mosi_bit;
  logic              rx_bit;
  logic              accept;

  // Last clk cycle index of one SCK half-period (H = 2^div).
  always_comb begin
    case (div_q)
      2'd0:    h_last = 3'd0;
      2'd1:    h_last = 3'd1;
      2'd2:    h_last = 3'd3;
      default: h_last = 3'd7;
    endcase
  end

  assign mosi_bit = fbo_q ? tx_q[0] : tx_q[DATA_W-1];
  assign accept   = (state_q == ST_IDLE) && bus.spi_start_i && armed_q;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = mosi_bit;
`else
  assign rx_bit = bus.MISO;
`endif

  // State register: control and the visible received word honour reset; shifters do not need to.
  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b1;
      fbo_q   <= 1'b0;
      div_q   <= 2'd0;
      cnt_q   <= 3'd0;
      phase_q <= 1'b0;
      bit_q   <= 6'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      fbo_q   <= fbo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge spi_clk_i) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    fbo_d   = fbo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;

    // Re-arm whenever start is seen low, so a held start cannot retrigger.
    if (!bus.spi_start_i) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_XFER;
          armed_d = 1'b0;
          tx_d    = bus.transmission_data_i;
          fbo_d   = bus.spi_fbo_i;
          div_d   = bus.clock_divider_i;
          cnt_d   = 3'd0;
          phase_d = 1'b0;
          bit_d   = 6'd0;
        end
      end

      ST_XFER: begin
        if (cnt_q == h_last) begin
          cnt_d = 3'd0;
          if (!phase_q) begin
            // SCK rising: capture the incoming bit.
            phase_d = 1'b1;
            rx_d    = fbo_q ? {rx_bit, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], rx_bit};
          end else begin
            // SCK falling: present the next transmit bit or finish.
            phase_d = 1'b0;
            tx_d    = fbo_q ? (tx_q >> 1) : (tx_q << 1);
            if (bit_q == 6'(DATA_W - 1)) begin
              state_d = ST_DONE;
              rdata_d = rx_q;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    bus.SS              = 1'b1;
    bus.SCK             = 1'b0;
    bus.MOSI            = 1'b0;
    bus.done            = 1'b0;
    bus.received_data_o = rdata_q;
    case (state_q)
      ST_XFER: begin
        bus.SS   = 1'b0;
        bus.SCK  = phase_q;
        bus.MOSI = mosi_bit;
      end
      ST_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.SS = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master; expectations switch to loopback values when
// SPI_MASTER_LOOPBACK_EN is defined for the build.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(48)) bus ();

  spi_master #(.DATA_W(48)) dut (
    .spi_clk_i (clk),
    .spi_rst_i (rst),
    .bus       (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rev48(input logic [47:0] d);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = d[47-i];
    return r;
  endfunction

  // miso_mode: 0 = MISO held 0, 1 = MISO held 1, 2 = MISO 1 for the first rising edge only.
  function automatic logic [47:0] exp_rx(input logic [47:0] data, input logic fbo, input int miso_mode);
`ifdef SPI_MASTER_LOOPBACK_EN
    return data;
`else
    case (miso_mode)
      0:       return 48'h0;
      1:       return 48'hFFFF_FFFF_FFFF;
      default: return fbo ? 48'h0000_0000_0001 : 48'h8000_0000_0000;
    endcase
`endif
  endfunction

  task automatic run_xfer(input string tag, input logic [47:0] data, input logic [1:0] div,
                          input logic fbo, input int miso_mode, input bit drop_start);
    int          ss_low = 0;
    int          rises = 0;
    int          cyc = 0;
    int          first_rise = -1;
    int          second_rise = -1;
    bit          seen_done = 1'b0;
    logic        prev_sck = 1'b0;
    logic [47:0] seq = '0;
    logic [47:0] rx_at_done = '0;
    logic        ss_at_done = 1'b0;
    logic        mosi_at_done = 1'b1;
    int          h;
    h = 1 << div;

    @(negedge clk);
    bus.transmission_data_i = data;
    bus.clock_divider_i     = div;
    bus.spi_fbo_i           = fbo;
    bus.MISO                = (miso_mode != 0);
    bus.spi_start_i         = 1'b1;

    @(negedge clk);
    check({tag, "_ss_low_after_accept"}, 48'(bus.SS), 48'd0);
    check({tag, "_first_mosi"}, 48'(bus.MOSI), 48'(fbo ? data[0] : data[47]));

    while (!seen_done && cyc < 2000) begin
      if (!bus.SS) ss_low++;
      if (bus.SCK && !prev_sck) begin
        rises++;
        seq = {seq[46:0], bus.MOSI};
        if (first_rise < 0) first_rise = cyc;
        else if (second_rise < 0) second_rise = cyc;
        if (miso_mode == 2) bus.MISO = 1'b0;
      end
      prev_sck = bus.SCK;
      if (bus.done) begin
        seen_done    = 1'b1;
        rx_at_done   = bus.received_data_o;
        ss_at_done   = bus.SS;
        mosi_at_done = bus.MOSI;
      end else begin
        cyc++;
        @(negedge clk);
      end
    end
    if (drop_start) bus.spi_start_i = 1'b0;

    check({tag, "_done_seen"}, 48'(seen_done), 48'd1);
    check({tag, "_sck_rises"}, 48'(rises), 48'd48);
    check({tag, "_ss_low_cycles"}, 48'(ss_low), 48'(96 * h));
    check({tag, "_sck_period"}, 48'(second_rise - first_rise), 48'(2 * h));
    check({tag, "_mosi_seq"}, seq, fbo ? rev48(data) : data);
    check({tag, "_rx_at_done"}, rx_at_done, exp_rx(data, fbo, miso_mode));
    check({tag, "_ss_at_done"}, 48'(ss_at_done), 48'd1);
    check({tag, "_mosi_at_done"}, 48'(mosi_at_done), 48'd0);

    @(negedge clk);
    check({tag, "_done_one_cycle"}, 48'(bus.done), 48'd0);
    check({tag, "_rx_held"}, bus.received_data_o, exp_rx(data, fbo, miso_mode));
  endtask

  initial begin
    int ss_seen;
    int done_seen;

    rst                     = 1'b1;
    bus.spi_fbo_i           = 1'b0;
    bus.spi_start_i         = 1'b0;
    bus.transmission_data_i = '0;
    bus.clock_divider_i     = 2'd0;
    bus.MISO                = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ss", 48'(bus.SS), 48'd1);
    check("rst_sck", 48'(bus.SCK), 48'd0);
    check("rst_mosi", 48'(bus.MOSI), 48'd0);
    check("rst_done", 48'(bus.done), 48'd0);
    check("rst_rx", bus.received_data_o, 48'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer("t1_msb_miso0", 48'h001F_001F_001F, 2'd0, 1'b0, 0, 1'b1);
    run_xfer("t2_lsb_miso1", 48'h001F_001F_001F, 2'd0, 1'b1, 1, 1'b1);
    run_xfer("t3_div3_msb", 48'h001F_001F_001F, 2'd3, 1'b0, 2, 1'b1);
    run_xfer("t4_div3_lsb", 48'h001F_001F_001F, 2'd3, 1'b1, 2, 1'b1);

    // Start held high across done: no second transfer until it drops.
    run_xfer("t5_hold", 48'hA5A5_1234_5678, 2'd1, 1'b0, 1, 1'b0);
    ss_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.SS) ss_seen++;
    end
    check("t5_no_retrigger", 48'(ss_seen), 48'd0);
    bus.spi_start_i = 1'b0;
    run_xfer("t6_rearm", 48'hA5A5_1234_5678, 2'd0, 1'b1, 0, 1'b1);

    // Reset in the middle of a transfer.
    @(negedge clk);
    bus.transmission_data_i = 48'hA5A5_1234_5678;
    bus.spi_fbo_i           = 1'b0;
    bus.clock_divider_i     = 2'd1;
    bus.spi_start_i         = 1'b1;
    repeat (50) @(negedge clk);
    check("t7_busy_before_rst", 48'(bus.SS), 48'd0);
    rst             = 1'b1;
    bus.spi_start_i = 1'b0;
    @(negedge clk);
    check("t7_rst_ss", 48'(bus.SS), 48'd1);
    check("t7_rst_sck", 48'(bus.SCK), 48'd0);
    check("t7_rst_mosi", 48'(bus.MOSI), 48'd0);
    check("t7_rst_done", 48'(bus.done), 48'd0);
    check("t7_rst_rx", bus.received_data_o, 48'd0);
    rst = 1'b0;
    done_seen = 0;
    ss_seen   = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (!bus.SS) ss_seen++;
    end
    check("t7_no_done_after_abort", 48'(done_seen), 48'd0);
    check("t7_stays_idle", 48'(ss_seen), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
